// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream blocks: width defaults, flit type, clog2 helper.
package stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } flit_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    if (v > 1) begin
      x = v - 1;
      while (x > 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with occupancy, watermarks and synchronous flush.
// Optional zero-latency bypass through an empty buffer: define STREAM_FIFO_BYPASS_EN.
module stream_fifo
  import stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned AFULL_LVL  = DEPTH - 2,
  parameter  int unsigned AEMPTY_LVL = 2,
  localparam int unsigned CNT_W      = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  o_ready,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_almost_full,
  output logic                  o_almost_empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stored_valid;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (i_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign stored_valid = (count_q != '0);
  assign i_ready      = (count_q != CNT_W'(DEPTH)) & ~i_flush;

`ifdef STREAM_FIFO_BYPASS_EN
  assign bypass = ~stored_valid & i_valid & o_ready & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word counts as handshaken on both sides but never touches storage.
  assign push = i_valid & i_ready & ~bypass;
  assign pop  = stored_valid & o_ready;

  assign o_valid        = stored_valid | bypass;
  assign o_data         = stored_valid ? rdata : (bypass ? i_data : '0);
  assign o_count        = count_q;
  assign o_almost_full  = 32'(count_q) >= AFULL_LVL;
  assign o_almost_empty = 32'(count_q) <= AEMPTY_LVL;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes.
module tb_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          i_flush;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_ready;
  logic [3:0]    o_count;
  logic          o_almost_full;
  logic          o_almost_empty;

  stream_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_ready        (o_ready),
    .o_count        (o_count),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] outlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words; outputs derived from its size and head.
  always @(negedge clk) begin
    int n;
    bit byp, e_ready, e_valid, do_pop, do_push;
    logic [DW-1:0] e_data;
    if (chk_en) begin
      n   = mq.size();
      byp = 1'b0;
`ifdef STREAM_FIFO_BYPASS_EN
      byp = (n == 0) && i_valid && o_ready && !i_flush;
`endif
      e_ready = (n != DEPTH) && !i_flush;
      e_valid = (n != 0) || byp;
      e_data  = (n != 0) ? mq[0] : (byp ? i_data : '0);
      chk("i_ready", 64'(i_ready), 64'(e_ready));
      chk("o_valid", 64'(o_valid), 64'(e_valid));
      chk("o_data", 64'(o_data), 64'(e_data));
      chk("o_count", 64'(o_count), 64'(n));
      chk("o_almost_full", 64'(o_almost_full), 64'(n >= DEPTH - 2));
      chk("o_almost_empty", 64'(o_almost_empty), 64'(n <= 2));
      if (o_valid && o_ready) outlog.push_back(o_data);
      if (reset || i_flush) begin
        mq.delete();
      end else begin
        do_pop  = (n != 0) && o_ready;
        do_push = e_ready && i_valid && !byp;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(i_data);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 2 * DEPTH + 4 && !done; c++) begin
      @(negedge clk);
      if (o_count == 0) done = 1'b1;
      else cycle();
    end
    if (!done) chk("drain_timeout", 64'(1), 64'(0));
    cycle();
  endtask

  initial begin
    logic [DW-1:0] exp_seq [9];
    bit done, acc;
    int acc_cycle;

    reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    reset = 1'b0;

    // Reset / idle
    @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'(1));
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_count", 64'(o_count), 64'(0));
    chk("rst_aempty", 64'(o_almost_empty), 64'(1));
    chk("rst_o_data", 64'(o_data), 64'(0));
    cycle();

    // Fill to full with back-pressure
    o_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_data  = DW'(k);
      cycle();
    end
    i_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("full_count", 64'(o_count), 64'(8));
    chk("full_i_ready", 64'(i_ready), 64'(0));
    chk("full_afull", 64'(o_almost_full), 64'(1));
    cycle();
    @(negedge clk);
    chk("full_held_count", 64'(o_count), 64'(8));
    cycle();

    // Drain from full while the held word waits for a slot
    outlog.delete();
    o_ready = 1'b1;
    done = 1'b0;
    acc_cycle = -1;
    for (int c = 0; c < 30 && !done; c++) begin
      acc = 1'b0;
      @(negedge clk);
      if (i_valid && i_ready) begin acc = 1'b1; acc_cycle = c; end
      if (!i_valid && o_count == 0) done = 1'b1;
      cycle();
      if (acc) i_valid = 1'b0;
    end
    if (!done) chk("drain_full_timeout", 64'(1), 64'(0));
    chk("deadbeef_accept_cycle", 64'(acc_cycle), 64'(1));
    for (int k = 0; k < 8; k++) exp_seq[k] = DW'(k + 1);
    exp_seq[8] = 32'hDEADBEEF;
    chk("drain_len", 64'(outlog.size()), 64'(9));
    for (int k = 0; k < 9; k++)
      if (k < outlog.size()) chk("drain_order", 64'(outlog[k]), 64'(exp_seq[k]));

    // Steady state at count 3, across pointer wrap
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = $urandom; cycle();
    end
    o_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      i_data = $urandom;
      @(negedge clk);
      chk("stream_count3", 64'(o_count), 64'(3));
      cycle();
    end
    drain();

    // Flush with a concurrent push attempt
    o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_data = 32'h100 + DW'(k); cycle();
    end
    i_flush = 1'b1; i_data = 32'h12345678;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(o_count), 64'(0));
    chk("flush_o_valid", 64'(o_valid), 64'(0));
    cycle();
    i_valid = 1'b1; i_data = 32'h00000055;
    cycle();
    i_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_count", 64'(o_count), 64'(1));
    chk("post_flush_data", 64'(o_data), 64'(32'h55));
    cycle();
    drain();

    // Reset mid-stream with handshakes pending
    o_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = $urandom; cycle();
    end
    reset = 1'b1; o_ready = 1'b1;
    cycle();
    reset = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    chk("midrst_count", 64'(o_count), 64'(0));
    chk("midrst_o_valid", 64'(o_valid), 64'(0));
    chk("midrst_o_data", 64'(o_data), 64'(0));
    chk("midrst_aempty", 64'(o_almost_empty), 64'(1));
    cycle();

`ifdef STREAM_FIFO_BYPASS_EN
    i_valid = 1'b1; o_ready = 1'b1; i_data = 32'hA5A5A5A5;
    @(negedge clk);
    chk("bypass_o_valid", 64'(o_valid), 64'(1));
    chk("bypass_o_data", 64'(o_data), 64'(32'hA5A5A5A5));
    cycle();
    i_valid = 1'b0;
    @(negedge clk);
    chk("bypass_count", 64'(o_count), 64'(0));
    cycle();
`endif

    // Randomized traffic honouring the hold-until-accepted rule
    i_valid = 1'b0;
    for (int k = 0; k < 600; k++) begin
      acc = 1'b0;
      @(negedge clk);
      acc = i_valid && i_ready;
      cycle();
      if (acc || !i_valid) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_data  = $urandom;
      end
      o_ready = ($urandom_range(0, 2) != 0);
      if (k > 300) o_ready = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 40) == 0);
    end
    i_flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parametrised valid/ready buffer. It is the successor to the single-register stream stage used throughout the datapath, generalised to DEPTH entries with occupancy reporting, watermarks and a synchronous flush. It sits between any two valid/ready stream interfaces to absorb back-pressure bursts. It has no combinational ready path from output to input, except when the optional bypass is compiled in.

Parameters:
DATA_WIDTH, 32, width of i_data/o_data in bits
DEPTH, 8, number of storage entries; must be >= 2; need not be a power of two
AFULL_LVL, DEPTH-2, o_almost_full asserted when count >= AFULL_LVL
AEMPTY_LVL, 2, o_almost_empty asserted when count <= AEMPTY_LVL
CNT_W, $clog2(DEPTH+1), width of o_count (derived; not overridden)

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  synchronous reset, active-high
i_flush  in  1  synchronous discard of all stored entries
i_valid  in  1  upstream data valid
i_data  in  DATA_WIDTH  upstream data
i_ready  out  1  buffer can accept this cycle
o_valid  out  1  head entry valid
o_data  out  DATA_WIDTH  head entry data
o_ready  in  1  downstream accepts this cycle
o_count  out  CNT_W  current occupancy, 0..DEPTH
o_almost_full  out  1  count >= AFULL_LVL
o_almost_empty  out  1  count <= AEMPTY_LVL

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset sampled on the rising edge of clk).
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0. This gives i_ready=1, o_valid=0, o_data=0, o_count=0, o_almost_full=0, o_almost_empty=1. Storage array is not reset.
- Reset mid-operation discards all entries. Any push or pop presented in the reset cycle has no effect.
- Transfer events: push = i_valid & i_ready; pop = o_valid & o_ready.
- i_ready = (count != DEPTH) & ~i_flush. It is a function of registered state only and never depends on o_ready.
- o_valid = (count != 0), registered-state only. o_data = mem[rd_ptr] when o_valid, else 0 (show-ahead).
- Latency: a word pushed at edge N is presented on o_valid/o_data after edge N, i.e. one cycle.
- Pointers increment on push/pop and wrap from DEPTH-1 to 0. Wrap uses an explicit compare, not power-of-two masking.
- count update: push & ~pop -> +1; pop & ~push -> -1; both or neither -> unchanged.
- Full (count = DEPTH): i_ready=0. A simultaneous pop does not enable a same-cycle push; the push is accepted the next cycle.
- Empty (count = 0): o_valid=0. A push does not produce output in the same cycle.
- Simultaneous push & pop at 0 < count < DEPTH: both happen and count holds.
- Data ordering: strict FIFO, no loss, no duplication.
- Flush priority: reset > i_flush > push/pop. With i_flush=1, the next edge zeroes both pointers and count. i_ready is 0 during the flush cycle. A pop presented in the flush cycle is still a valid handshake from the consumer's view (the data was shown), and the entry is discarded with the rest.
- Watermarks are combinational from registered count, so there are no glitches relative to o_count.
- Protocol obligations: the source holds i_valid/i_data stable until accepted. The block holds o_valid/o_data stable until popped or flushed.

Optional Feature:
Macro STREAM_FIFO_BYPASS_EN.
- Defined: when count=0, i_valid=1, o_ready=1 and i_flush=0, the input word passes combinationally. Then o_valid=1, o_data=i_data, and it is not stored (count stays 0).
- Defined: when count=0, i_ready additionally asserts regardless of o_ready state (unchanged from base).
- Defined: this gives zero-cycle latency through an empty buffer and adds a combinational i_valid->o_valid path.
- Undefined: no bypass; one-cycle minimum latency; no input-to-output combinational path.

Decomposition:
- Shared package stream_pkg:
  - clog2 helper function.
  - Default DATA_WIDTH constant.
  - Flit/handshake struct typedef (valid, data) reused by other stream blocks.
- Sub-module stream_fifo_mem: DEPTH x DATA_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count, flush and bypass control stay in stream_fifo.

Test Plan:
- Reset then idle -> i_ready=1, o_valid=0, o_count=0, o_almost_empty=1, o_data=0.
- o_ready=0; push 0x00000001..0x00000008 with DEPTH=8 -> i_ready drops after the 8th accept; o_count=8; o_almost_full=1 from count 6. A 9th word 0xDEADBEEF is held, not accepted.
- From full, set o_ready=1 and keep i_valid=1 -> outputs 0x01..0x08 in order. 0xDEADBEEF is accepted the cycle after the first pop and emerges 9th. Count never exceeds 8.
- Continuous i_valid/o_ready with count=3 and random data -> throughput of 1 word/cycle; count holds at 3; order preserved across pointer wrap (≥20 words).
- Load 5 words, assert i_flush for 1 cycle with i_valid=1 and data 0x12345678 -> next cycle o_count=0, o_valid=0; 0x12345678 is not stored. A push the cycle after the flush returns normally.
- Load 4 words, assert reset mid-stream -> all outputs return to reset values after the edge. With STREAM_FIFO_BYPASS_EN defined and empty: i_valid=1, o_ready=1, data 0xA5A5A5A5 -> o_valid=1, o_data=0xA5A5A5A5 in the same cycle, o_count stays 0.
